// File: rtl/cache_types_pkg.sv
// Shared types for the 2-way write-back data cache: address split, frame layout, controller states.
package cache_types_pkg;
  localparam int IDX_W = 3;
  localparam int TAG_W = 26;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic             blkoff;
    logic [1:0]       bytoff;
  } dcachef_t;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
    logic [1:0][31:0] data;
  } dcache_frame_t;

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, LD0, LD1, FLUSH, FWB0, FWB1, FLUSHED
  } dstate_t;
endpackage

// File: rtl/dcache_set.sv
// One cache index: two frames plus an LRU bit; combinational tag lookup and victim pick.
// Writes land on the next CLK edge; no flow control of its own, the controller sequences it.
module dcache_set
  import cache_types_pkg::*;
(
  input  logic                CLK,
  input  logic                nRST,
  input  logic [TAG_W-1:0]    lk_tag,
  input  logic                way,
  input  logic                wr_en,
  input  logic                wr_blk,
  input  logic [31:0]         wr_dat,
  input  logic                mark_dirty,
  input  logic                clean_en,
  input  logic                fill_done,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic                touch_en,
  output logic                hit,
  output logic                hit_way,
  output logic                victim_way,
  output dcache_frame_t [1:0] frames
);
  logic       lru;
  logic [1:0] match;

  assign match[0] = frames[0].valid && (frames[0].tag == lk_tag);
  assign match[1] = frames[1].valid && (frames[1].tag == lk_tag);
  assign hit      = |match;
  assign hit_way  = !match[0];

  // An empty way is always preferred over evicting a live line.
  always_comb begin
    victim_way = lru;
    if (!frames[0].valid)      victim_way = 1'b0;
    else if (!frames[1].valid) victim_way = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      frames <= '0;
      lru    <= 1'b0;
    end else begin
      if (wr_en)      frames[way].data[wr_blk] <= wr_dat;
      if (mark_dirty) frames[way].dirty <= 1'b1;
      if (clean_en)   frames[way].dirty <= 1'b0;
      if (fill_done) begin
        frames[way].valid <= 1'b1;
        frames[way].dirty <= 1'b0;
        frames[way].tag   <= fill_tag;
      end
      if (touch_en)   lru <= ~way;
    end
  end
endmodule

// File: rtl/dcache_wb2way.sv
// Write-back 2-way L1 D-cache: hits complete combinationally, misses do writeback then a two-word fill.
// Memory backpressure (dwait) stalls WB/LD/FWB states; the datapath sees dhit=0 until its access is done.
module dcache_wb2way
  import cache_types_pkg::*;
#(
  parameter int SETS  = 8,
  parameter int CPUID = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        datomic,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);
  dstate_t          state, nxt_state;
  logic [4:0]       cnt, nxt_cnt;
  logic [TAG_W-1:0] m_tag, nxt_m_tag;
  logic [IDX_W-1:0] m_idx, nxt_m_idx;
  logic             v_way, nxt_v_way;
  logic             link_vld, nxt_link_vld;
  logic [31:0]      link_addr, nxt_link_addr;

  dcachef_t         req;
  logic [IDX_W-1:0] sel_idx;
  logic             fl_way, link_hit, wb_blk;
  logic             hit_a [SETS];
  logic             hway_a [SETS];
  logic             vway_a [SETS];
  dcache_frame_t [1:0] fr_a [SETS];
  dcache_frame_t    vic_fr;

  logic             op_way, wr_en, wr_blk, mark_dirty, clean_en, fill_done, touch_en;
  logic [31:0]      wr_dat;

  logic unused_cpuid;
  assign unused_cpuid = (CPUID != 0);

  assign req      = dmemaddr;
  assign link_hit = link_vld && (link_addr == dmemaddr);
  assign wb_blk   = (state == WB1) || (state == FWB1);

  // Miss sequencing uses the latched index so a dropped request cannot redirect the fill.
  always_comb begin
    sel_idx = req.idx;
    fl_way  = vway_a[req.idx];
    if (state inside {WB0, WB1, LD0, LD1}) begin
      sel_idx = m_idx;
      fl_way  = v_way;
    end else if (state inside {FLUSH, FWB0, FWB1}) begin
      sel_idx = cnt[2:0];
      fl_way  = cnt[3];
    end
  end

  assign vic_fr = fr_a[sel_idx][fl_way];

  for (genvar i = 0; i < SETS; i++) begin : g_set
    logic sel;
    assign sel = (sel_idx == IDX_W'(i));
    dcache_set u_set (
      .CLK        (CLK),
      .nRST       (nRST),
      .lk_tag     (req.tag),
      .way        (op_way),
      .wr_en      (wr_en && sel),
      .wr_blk     (wr_blk),
      .wr_dat     (wr_dat),
      .mark_dirty (mark_dirty && sel),
      .clean_en   (clean_en && sel),
      .fill_done  (fill_done && sel),
      .fill_tag   (m_tag),
      .touch_en   (touch_en && sel),
      .hit        (hit_a[i]),
      .hit_way    (hway_a[i]),
      .victim_way (vway_a[i]),
      .frames     (fr_a[i])
    );
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      cnt       <= '0;
      m_tag     <= '0;
      m_idx     <= '0;
      v_way     <= 1'b0;
      link_vld  <= 1'b0;
      link_addr <= '0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      m_tag     <= nxt_m_tag;
      m_idx     <= nxt_m_idx;
      v_way     <= nxt_v_way;
      link_vld  <= nxt_link_vld;
      link_addr <= nxt_link_addr;
    end
  end

  always_comb begin
    nxt_state     = state;
    nxt_cnt       = cnt;
    nxt_m_tag     = m_tag;
    nxt_m_idx     = m_idx;
    nxt_v_way     = v_way;
    nxt_link_vld  = link_vld;
    nxt_link_addr = link_addr;
    dhit          = 1'b0;
    dmemload      = '0;
    flushed       = 1'b0;
    dREN          = 1'b0;
    dWEN          = 1'b0;
    daddr         = '0;
    dstore        = '0;
    op_way        = fl_way;
    wr_en         = 1'b0;
    wr_blk        = 1'b0;
    wr_dat        = '0;
    mark_dirty    = 1'b0;
    clean_en      = 1'b0;
    fill_done     = 1'b0;
    touch_en      = 1'b0;

    case (state)
      IDLE: begin
        if (halt) begin
          nxt_state = FLUSH;
          nxt_cnt   = '0;
        end else if (dmemREN || dmemWEN) begin
          if (datomic && dmemWEN && !link_hit) begin
            dhit         = 1'b1;
            nxt_link_vld = 1'b0;
          end else if (hit_a[sel_idx]) begin
            dhit     = 1'b1;
            touch_en = 1'b1;
            op_way   = hway_a[sel_idx];
            if (dmemWEN) begin
              wr_en      = 1'b1;
              wr_blk     = req.blkoff;
              wr_dat     = dmemstore;
              mark_dirty = 1'b1;
              if (link_hit) nxt_link_vld = 1'b0;
              if (datomic)  dmemload = 32'd1;
            end else begin
              dmemload = fr_a[sel_idx][hway_a[sel_idx]].data[req.blkoff];
              if (datomic) begin
                nxt_link_vld  = 1'b1;
                nxt_link_addr = dmemaddr;
              end
            end
          end else begin
            nxt_m_tag = req.tag;
            nxt_m_idx = req.idx;
            nxt_v_way = fl_way;
            nxt_state = vic_fr.dirty ? WB0 : LD0;
          end
        end
      end
      WB0, WB1, FWB0, FWB1: begin
        dWEN   = 1'b1;
        daddr  = {vic_fr.tag, sel_idx, wb_blk, 2'b00};
        dstore = vic_fr.data[wb_blk];
        if (!dwait) begin
          case (state)
            WB0:     nxt_state = WB1;
            WB1:     nxt_state = LD0;
            FWB0:    nxt_state = FWB1;
            default: begin
              clean_en  = 1'b1;
              nxt_state = (cnt == 5'd15) ? FLUSHED : FLUSH;
              nxt_cnt   = cnt + 5'd1;
            end
          endcase
        end
      end
      LD0, LD1: begin
        dREN  = 1'b1;
        daddr = {m_tag, m_idx, (state == LD1), 2'b00};
        if (!dwait) begin
          wr_en  = 1'b1;
          wr_blk = (state == LD1);
          wr_dat = dload;
          if (state == LD0) begin
            nxt_state = LD1;
          end else begin
            fill_done = 1'b1;
            nxt_state = IDLE;
            if (dmemWEN && !datomic && link_hit) nxt_link_vld = 1'b0;
          end
        end
      end
      FLUSH: begin
        if (vic_fr.dirty) begin
          nxt_state = FWB0;
        end else if (cnt == 5'd15) begin
          nxt_state = FLUSHED;
        end else begin
          nxt_cnt = cnt + 5'd1;
        end
      end
      FLUSHED: flushed = 1'b1;
      default: nxt_state = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dcache_wb2way.sv
// Scoreboard bench for dcache_wb2way: stimulus queues expected hits and memory writes, monitors pop and compare.
module tb_dcache_wb2way;
  logic        CLK = 1'b0;
  logic        nRST, halt, dmemREN, dmemWEN, datomic;
  logic [31:0] dmemaddr, dmemstore;
  logic        dhit, flushed, dREN, dWEN;
  logic [31:0] dmemload, daddr, dstore, dload;
  logic        dwait = 1'b1;
  logic        busy  = 1'b1;

  always #5 CLK = ~CLK;

  dcache_wb2way #(.SETS(8), .CPUID(0)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .datomic(datomic), .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit),
    .dmemload(dmemload), .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
    .dstore(dstore), .dwait(dwait), .dload(dload)
  );

  typedef struct packed { logic chk; logic [31:0] dat; } hexp_t;
  typedef struct packed { logic [31:0] a; logic [31:0] d; } wexp_t;

  hexp_t       hit_q[$];
  wexp_t       wr_q[$];
  hexp_t       he;
  wexp_t       we;
  logic [31:0] mem [1024];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_wr   = 0;

  assign dload = mem[daddr[11:2]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, want);
  endtask

  // Memory model: each access waits one cycle (dwait=1) then completes with dwait=0.
  always @(negedge CLK) begin
    if (!nRST) begin
      dwait = 1'b1;
      busy  = 1'b1;
    end else if (dREN || dWEN) begin
      if (busy) begin
        dwait = 1'b1;
        busy  = 1'b0;
      end else begin
        dwait = 1'b0;
        busy  = 1'b1;
        if (dWEN) begin
          mem[daddr[11:2]] = dstore;
          n_wr++;
          if (wr_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_write: addr %h data %h, expected no write", daddr, dstore);
          end else begin
            we = wr_q.pop_front();
            check("wb_addr", daddr, we.a);
            check("wb_data", dstore, we.d);
          end
        end
      end
    end else begin
      dwait = 1'b1;
      busy  = 1'b1;
    end
  end

  // Hit monitor: every dhit consumes one scoreboard entry.
  always @(negedge CLK) begin
    if (nRST && dhit) begin
      if (hit_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_hit: dhit=%b at addr %h, expected 0", dhit, dmemaddr);
      end else begin
        he = hit_q.pop_front();
        if (he.chk) check("dmemload", dmemload, he.dat);
      end
    end
  end

  task automatic access(input string name, input logic wen, input logic at,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic chk, input logic [31:0] want, input logic exp_miss);
    int n = 0;
    hit_q.push_back({chk, want});
    @(posedge CLK); #1;
    dmemREN = !wen; dmemWEN = wen; datomic = at; dmemaddr = a; dmemstore = d;
    @(negedge CLK);
    while (!dhit && n < 200) begin
      n++;
      @(negedge CLK);
    end
    if (n >= 200) check({name, "_timeout"}, {31'b0, dhit}, 32'd1);
    else check({name, "_miss"}, {31'b0, (n > 0)}, {31'b0, exp_miss});
    @(posedge CLK); #1;
    dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dhit"},     {31'b0, dhit},    32'd0);
    check({tag, "_flushed"},  {31'b0, flushed}, 32'd0);
    check({tag, "_dren"},     {31'b0, dREN},    32'd0);
    check({tag, "_dwen"},     {31'b0, dWEN},    32'd0);
    check({tag, "_daddr"},    daddr,            32'd0);
    check({tag, "_dmemload"}, dmemload,         32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nw0;
    for (int i = 0; i < 1024; i++) mem[i] = init_val(32'(i * 4));
    nRST = 1'b0; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
    dmemaddr = '0; dmemstore = '0;
    repeat (2) @(negedge CLK);
    check_reset_outputs("rst0");
    #1 nRST = 1'b1;

    // Cold fill of set 0 way 0, then same-block hit
    access("ld40", 1'b0, 1'b0, 32'h40, 0, 1'b1, init_val(32'h40), 1'b1);
    access("ld44", 1'b0, 1'b0, 32'h44, 0, 1'b1, init_val(32'h44), 1'b0);

    // Dirty 0x40, fill way1 with 0x80, then 0xC0 evicts the LRU (dirty) way0
    access("st40", 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 1'b0, 0, 1'b0);
    access("ld80", 1'b0, 1'b0, 32'h80, 0, 1'b1, init_val(32'h80), 1'b1);
    wr_q.push_back({32'h40, 32'hDEADBEEF});
    wr_q.push_back({32'h44, init_val(32'h44)});
    access("ldC0", 1'b0, 1'b0, 32'hC0, 0, 1'b1, init_val(32'hC0), 1'b1);

    // LRU tracking: last touch decides the victim
    access("hit80", 1'b0, 1'b0, 32'h80, 0, 1'b1, init_val(32'h80), 1'b0);
    access("hitC0", 1'b0, 1'b0, 32'hC0, 0, 1'b1, init_val(32'hC0), 1'b0);
    access("hit80b", 1'b0, 1'b0, 32'h80, 0, 1'b1, init_val(32'h80), 1'b0);
    access("re40", 1'b0, 1'b0, 32'h40, 0, 1'b1, 32'hDEADBEEF, 1'b1);
    access("reC0", 1'b0, 1'b0, 32'hC0, 0, 1'b1, init_val(32'hC0), 1'b1);
    access("keep40", 1'b0, 1'b0, 32'h40, 0, 1'b1, 32'hDEADBEEF, 1'b0);

    // LL/SC success, then a plain store breaking the link
    access("ll100", 1'b0, 1'b1, 32'h100, 0, 1'b1, init_val(32'h100), 1'b1);
    access("sc100ok", 1'b1, 1'b1, 32'h100, 32'd5, 1'b1, 32'd1, 1'b0);
    access("ll100b", 1'b0, 1'b1, 32'h100, 0, 1'b1, 32'd5, 1'b0);
    access("sw100", 1'b1, 1'b0, 32'h100, 32'd7, 1'b0, 0, 1'b0);
    access("sc100bad", 1'b1, 1'b1, 32'h100, 32'd9, 1'b1, 32'd0, 1'b0);
    access("ld100", 1'b0, 1'b0, 32'h100, 0, 1'b1, 32'd7, 1'b0);

    // Dirty way1 frames in sets 2 and 7
    access("ld10", 1'b0, 1'b0, 32'h10, 0, 1'b1, init_val(32'h10), 1'b1);
    access("st50", 1'b1, 1'b0, 32'h50, 32'h22222222, 1'b0, 0, 1'b1);
    access("ld38", 1'b0, 1'b0, 32'h38, 0, 1'b1, init_val(32'h38), 1'b1);
    access("st7C", 1'b1, 1'b0, 32'h7C, 32'h77777777, 1'b0, 0, 1'b1);

    // Flush: way0 all clean; way1 sets 0, 2, 7 dirty, in that order
    wr_q.push_back({32'h100, 32'd7});
    wr_q.push_back({32'h104, init_val(32'h104)});
    wr_q.push_back({32'h50, 32'h22222222});
    wr_q.push_back({32'h54, init_val(32'h54)});
    wr_q.push_back({32'h78, init_val(32'h78)});
    wr_q.push_back({32'h7C, 32'h77777777});
    nw0 = n_wr;
    @(posedge CLK); #1 halt = 1'b1;
    n = 0;
    while (!flushed && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check("flushed", {31'b0, flushed}, 32'd1);
    check("flush_writes", n_wr - nw0, 32'd6);
    check("flush_pending", wr_q.size(), 32'd0);
    @(posedge CLK); #1 dmemREN = 1'b1; dmemaddr = 32'h40;
    repeat (4) begin
      @(negedge CLK);
      check("flushed_hold", {31'b0, flushed}, 32'd1);
      check("flushed_nohit", {31'b0, dhit}, 32'd0);
    end

    // Reset clears FLUSHED
    @(posedge CLK); #1 dmemREN = 1'b0; halt = 1'b0; nRST = 1'b0;
    @(negedge CLK);
    check_reset_outputs("rst1");
    #1 nRST = 1'b1;

    // Reset in LD1 while memory is stalling drops dREN at once
    @(posedge CLK); #1 dmemREN = 1'b1; dmemaddr = 32'h200;
    n = 0;
    @(negedge CLK);
    while (!(dREN && daddr == 32'h204) && n < 100) begin
      n++;
      @(negedge CLK);
    end
    #1;
    check("ld1_dwait", {31'b0, dwait}, 32'd1);
    check("ld1_daddr", daddr, 32'h204);
    nRST = 1'b0;
    #1;
    check("rst_dren_drop", {31'b0, dREN}, 32'd0);
    check("rst_dwen_drop", {31'b0, dWEN}, 32'd0);
    dmemREN = 1'b0;
    @(negedge CLK); #1 nRST = 1'b1;

    // Caches cold again; memory holds written-back data
    access("post40", 1'b0, 1'b0, 32'h40, 0, 1'b1, 32'hDEADBEEF, 1'b1);
    access("post100", 1'b0, 1'b0, 32'h100, 0, 1'b1, 32'd7, 1'b1);
    access("post44", 1'b0, 1'b0, 32'h44, 0, 1'b1, init_val(32'h44), 1'b0);

    repeat (3) @(negedge CLK);
    check("hit_q_empty", hit_q.size(), 32'd0);
    check("wr_q_empty", wr_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
